// File: rtl/pipeline_stage_buffer_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_buffer_pkg
// Shared types and helpers for the elastic stage buffer.
//   decode_to_execute_t : packed decode->execute stage payload.
//   D2E_W               : payload width for instantiating the buffer.
//   MAX_DEPTH           : largest supported buffer depth.
//   wrap_inc()          : circular pointer increment for any depth.
// -----------------------------------------------------------------------------
package pipeline_stage_buffer_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        halt;
        logic        dwrite;
        logic        csr_write;
        logic [3:0]  alu_op;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic        branch;
        logic [31:0] branch_target;
    } decode_to_execute_t;

    localparam int D2E_W     = $bits(decode_to_execute_t);
    localparam int MAX_DEPTH = 8;

    // Depth need not be a power of two, so wrap with a compare, not a modulo.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        int unsigned nxt;
        if (ptr == depth - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pipeline_stage_buffer_if.sv
// -----------------------------------------------------------------------------
// pipeline_stage_buffer_if
// valid/ready/data handshake bundle between two pipeline stages.
//   master : drives valid and data, samples ready (producer side).
//   slave  : samples valid and data, drives ready (consumer side).
// -----------------------------------------------------------------------------
interface pipeline_stage_buffer_if #(
    parameter int WIDTH = 128
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_stage_buffer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating event counter, reusable for performance statistics.
//   clk, rst : clock, synchronous active-high reset
//   inc_i    : count one event this cycle
//   clr_i    : synchronous clear, wins over inc_i
//   count_o  : registered count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear first, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {W{1'b0}};
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/pipeline_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipeline_stage_buffer
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready
// handshake, synchronous flush, zero-payload bubble when empty and a
// saturating stall-cycle counter.
//   clk, rst       : clock, synchronous active-high reset
//   flush_i        : drop every entry this cycle
//   clr_stats_i    : clear the stall counter
//   in_if (slave)  : upstream valid/ready/data
//   out_if (master): downstream valid/ready/data (data is zero when empty)
//   count_o        : occupied entries
//   stall_cycles_o : cycles with head valid but not consumed
// -----------------------------------------------------------------------------
module pipeline_stage_buffer
    import pipeline_stage_buffer_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 2,
    parameter int PIPE_READY = 0,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         clr_stats_i,
    pipeline_stage_buffer_if.slave       in_if,
    pipeline_stage_buffer_if.master      out_if,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [CNT_W-1:0]             stall_cycles_o
);
    localparam int   CW      = $clog2(DEPTH + 1);
    localparam int   PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic PIPE_EN = (PIPE_READY != 0);

    // Payload storage is deliberately not reset; the empty-state mask supplies the bubble.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic not_full_s;
    logic ready_s;
    logic out_valid_s;
    logic push_s;
    logic pop_s;
    logic stall_inc_s;

    // Handshake decode. With PIPE_EN=0 out_if.ready never reaches in_if.ready.
    always_comb begin
        not_full_s  = (count_q < CW'(DEPTH));
        ready_s     = not_full_s | (PIPE_EN & out_if.ready);
        out_valid_s = (count_q != {CW{1'b0}});
        push_s      = in_if.valid & ready_s & ~flush_i;
        pop_s       = out_valid_s & out_if.ready & ~flush_i;
        stall_inc_s = out_valid_s & ~out_if.ready & ~flush_i;
    end

    // Pointer and occupancy next state; flush beats push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), 32'(DEPTH)));
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), 32'(DEPTH)));
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload write; a push presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q] <= in_if.data;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_inc_s),
        .clr_i   (clr_stats_i),
        .count_o (stall_cycles_o)
    );

    // in_ready is forced high while reset is held so upstream never sees a stall there.
    assign in_if.ready  = rst | ready_s;
    assign out_if.valid = out_valid_s;
    assign out_if.data  = out_valid_s ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
    assign count_o      = count_q;
endmodule
